// File: rtl/spi_sevenseg_scan_ctrl.sv
// SPI-loaded four-digit seven-segment driver: a byte-wide receiver updates
// per-digit data and an enable mask while a free-running scanner multiplexes the digits.
module spi_sevenseg_scan_ctrl #(
   parameter int SCAN_DIV  = 256,
   parameter int BLANK_CYC = 4
) (
   input  logic       sclk,
   input  logic       rst_n,
   input  logic       ss,
   input  logic       mosi,
   output logic [7:0] seg,
   output logic [3:0] dig_en,
   output logic       frame_done
);

   localparam int CNT_W = $clog2(SCAN_DIV);

   typedef enum logic [1:0] {
      CMD_WR    = 2'b00,
      CMD_WR_DP = 2'b01,
      CMD_CLR   = 2'b10,
      CMD_MASK  = 2'b11
   } cmd_e;

   logic [2:0]       bit_cnt;
   logic [7:0]       shift_q;
   logic [7:0]       frame_q;
   logic             frame_pend;
   logic [3:0]       nib_q [4];
   logic [3:0]       dp_q;
   logic [3:0]       valid_q;
   logic [3:0]       mask_q;
   logic [CNT_W-1:0] scan_cnt;
   logic [1:0]       slot;
   logic [7:0]       seg_d;
   logic [3:0]       dig_d;
   cmd_e             cmd;
   logic [1:0]       addr;

   function automatic logic [6:0] font(input logic [3:0] n);
      logic [6:0] f;
      case (n)
         4'h0: f = 7'h3F;  4'h1: f = 7'h06;  4'h2: f = 7'h5B;  4'h3: f = 7'h4F;
         4'h4: f = 7'h66;  4'h5: f = 7'h6D;  4'h6: f = 7'h7D;  4'h7: f = 7'h07;
         4'h8: f = 7'h7F;  4'h9: f = 7'h6F;  4'hA: f = 7'h77;  4'hB: f = 7'h7C;
         4'hC: f = 7'h39;  4'hD: f = 7'h5E;  4'hE: f = 7'h79;  default: f = 7'h71;
      endcase
      return f;
   endfunction

   // The completed byte is latched on the 8th-bit edge and applied one edge later.
   // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
   always_ff @(posedge sclk) begin
      if (!rst_n) begin
         bit_cnt    <= '0;
         shift_q    <= '0;
         frame_q    <= '0;
         frame_pend <= 1'b0;
      end else begin
         frame_pend <= 1'b0;
         if (ss) begin
            bit_cnt <= '0;
         end else begin
            shift_q <= {shift_q[6:0], mosi};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               frame_q    <= {shift_q[6:0], mosi};
               frame_pend <= 1'b1;
            end
         end
      end
   end

   assign cmd  = cmd_e'(frame_q[7:6]);
   assign addr = frame_q[5:4];

   // NOTE: the nibble array is four small flop words, so it is cleared on reset like any other register.
   always_ff @(posedge sclk) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) nib_q[i] <= '0;
         dp_q       <= '0;
         valid_q    <= '0;
         mask_q     <= 4'b1111;
         frame_done <= 1'b0;
      end else begin
         frame_done <= frame_pend;
         if (frame_pend) begin
            case (cmd)
               CMD_WR, CMD_WR_DP: begin
                  nib_q[addr]   <= frame_q[3:0];
                  dp_q[addr]    <= (cmd == CMD_WR_DP);
                  valid_q[addr] <= 1'b1;
               end
               CMD_CLR: begin
                  dp_q    <= '0;
                  valid_q <= '0;
               end
               default: mask_q <= frame_q[3:0];
            endcase
         end
      end
   end

   always_ff @(posedge sclk) begin
      if (!rst_n) begin
         scan_cnt <= '0;
         slot     <= '0;
      end else if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
         scan_cnt <= '0;
         slot     <= slot + 2'd1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   // NOTE: both outputs get a default before any branch so this block never infers a latch.
   always_comb begin
      seg_d = '0;
      dig_d = '0;
      if (scan_cnt >= CNT_W'(BLANK_CYC) && mask_q[slot]) begin
         dig_d = 4'b0001 << slot;
         if (valid_q[slot]) seg_d = {dp_q[slot], font(nib_q[slot])};
      end
   end

   always_ff @(posedge sclk) begin
      if (!rst_n) begin
         seg    <= '0;
         dig_en <= '0;
      end else begin
         seg    <= seg_d;
         dig_en <= dig_d;
      end
   end

endmodule

// File: tb/tb_spi_sevenseg_scan_ctrl.sv
// Directed bench for spi_sevenseg_scan_ctrl with SCAN_DIV=16, BLANK_CYC=4:
// a frame/expected-display table plus hand sequences for abort, back-to-back, mask and reset.
module tb_spi_sevenseg_scan_ctrl;

   logic       sclk = 1'b0;
   logic       rst_n;
   logic       ss;
   logic       mosi;
   logic [7:0] seg;
   logic [3:0] dig_en;
   logic       frame_done;

   int n_pass  = 0;
   int n_total = 0;
   int k       = -1;   // edges since reset release; output after edge k shows count k%16, slot (k/16)%4

   typedef struct {
      logic [7:0] frame;
      int         slot;
      logic [7:0] exp_seg;
      logic [3:0] exp_dig;
   } vec_t;

   vec_t vecs [5];

   spi_sevenseg_scan_ctrl #(.SCAN_DIV(16), .BLANK_CYC(4)) dut (
      .sclk       (sclk),
      .rst_n      (rst_n),
      .ss         (ss),
      .mosi       (mosi),
      .seg        (seg),
      .dig_en     (dig_en),
      .frame_done (frame_done)
   );

   always #5 sclk = ~sclk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h (k=%0d)", name, act, exp, k);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge sclk);
      #1;
      if (rst_n) k++;
      else k = -1;
   endtask

   task automatic send_frame(input logic [7:0] b, input string name);
      for (int i = 7; i >= 0; i--) begin
         ss   = 1'b0;
         mosi = b[i];
         tick();
      end
      ss = 1'b1;
      check({name, "_fd_early"}, frame_done, 1'b0);
      tick();
      check({name, "_fd"}, frame_done, 1'b1);
      tick();
      check({name, "_fd_end"}, frame_done, 1'b0);
   endtask

   // Advance to the middle of the given slot's lit window.
   task automatic view(input int s);
      int n = 0;
      while (k < 0 || (k % 64) != s * 16 + 8) begin
         tick();
         n++;
         if (n > 100) begin
            n_total++;
            $display("FAIL view_timeout: slot %0d not reached", s);
            return;
         end
      end
   endtask

   task automatic view_check(input int s, input logic [7:0] e_seg, input logic [3:0] e_dig,
                             input string name);
      view(s);
      check({name, "_seg"}, seg, e_seg);
      check({name, "_dig"}, dig_en, e_dig);
   endtask

   initial begin
      logic [17:0] fd_seen;
      logic [3:0]  exp_dig;

      vecs[0] = '{8'h05, 0, 8'h6D, 4'b0001};
      vecs[1] = '{8'h78, 3, 8'hFF, 4'b1000};
      vecs[2] = '{8'h4A, 0, 8'hF7, 4'b0001};
      vecs[3] = '{8'h1C, 1, 8'h39, 4'b0010};
      vecs[4] = '{8'h3E, 3, 8'h79, 4'b1000};

      rst_n = 1'b0;
      ss    = 1'b1;
      mosi  = 1'b0;
      repeat (3) tick();
      check("rst_seg", seg, 8'h00);
      check("rst_dig", dig_en, 4'h0);
      check("rst_fd", frame_done, 1'b0);

      // Idle scan: four blank cycles then twelve lit cycles per slot, nothing valid.
      rst_n = 1'b1;
      for (int i = 0; i < 64; i++) begin
         tick();
         exp_dig = ((k % 16) >= 4) ? (4'b0001 << ((k / 16) % 4)) : 4'b0000;
         check("idle_scan", {seg, dig_en}, {8'h00, exp_dig});
      end

      for (int i = 0; i < 5; i++) begin
         send_frame(vecs[i].frame, $sformatf("vec%0d", i));
         view_check(vecs[i].slot, vecs[i].exp_seg, vecs[i].exp_dig, $sformatf("vec%0d", i));
      end

      // Abort after 5 bits of 0x1A: no pulse, digit 1 keeps its old value.
      fd_seen = '0;
      for (int i = 7; i >= 3; i--) begin
         ss   = 1'b0;
         mosi = (8'h1A >> i) & 8'h01;
         tick();
         fd_seen[i] = frame_done;
      end
      ss = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         fd_seen[8 + i] = frame_done;
      end
      check("abort_no_fd", fd_seen, 18'h0);
      view_check(1, 8'h39, 4'b0010, "abort_keep");
      send_frame(8'h12, "after_abort");
      view_check(1, 8'h5B, 4'b0010, "after_abort");

      // Two frames back-to-back with ss held low: pulses one edge after bits 8 and 16.
      fd_seen = '0;
      for (int i = 0; i < 18; i++) begin
         if (i < 16) begin
            ss   = 1'b0;
            mosi = (i < 8) ? ((8'h2F >> (7 - i)) & 8'h01) : ((8'h33 >> (15 - i)) & 8'h01);
         end else begin
            ss = 1'b1;
         end
         tick();
         fd_seen[i] = frame_done;
      end
      check("b2b_fd_pattern", fd_seen, 18'h10100);
      view_check(2, 8'h71, 4'b0100, "b2b_d2");
      // 0x33 carries command 00, so digit 3 is written with its point off.
      view_check(3, 8'h4F, 4'b1000, "b2b_d3");

      // Mask 0101: slots 1 and 3 stay dark but still take their time.
      send_frame(8'hC5, "mask");
      view_check(0, 8'hF7, 4'b0001, "mask_d0");
      view_check(1, 8'h00, 4'b0000, "mask_d1");
      view_check(2, 8'h71, 4'b0100, "mask_d2");
      view_check(3, 8'h00, 4'b0000, "mask_d3");
      send_frame(8'h80, "clear");
      view_check(0, 8'h00, 4'b0001, "clear_d0");
      view_check(2, 8'h00, 4'b0100, "clear_d2");
      send_frame(8'hCF, "mask_all");
      view_check(3, 8'h00, 4'b1000, "clear_d3");

      // Write to the digit on display: new value visible two edges after the 8th bit.
      while ((k % 64) != 4) tick();
      send_frame(8'h07, "live");
      check("live_seg", seg, 8'h07);
      check("live_dig", dig_en, 4'b0001);

      // Reset mid-frame while a valid digit is lit.
      send_frame(8'hC1, "mask_d0_only");
      send_frame(8'h05, "pre_rst");
      view_check(0, 8'h6D, 4'b0001, "pre_rst");
      for (int i = 7; i >= 4; i--) begin
         ss   = 1'b0;
         mosi = (8'hD0 >> i) & 8'h01;
         tick();
      end
      mosi  = 1'b0;
      rst_n = 1'b0;
      tick();
      check("midrst_seg", seg, 8'h00);
      check("midrst_dig", dig_en, 4'h0);
      check("midrst_fd", frame_done, 1'b0);
      rst_n = 1'b1;
      send_frame(8'h16, "post_rst");
      view_check(0, 8'h00, 4'b0001, "post_rst_d0");
      view_check(1, 8'h7D, 4'b0010, "post_rst_d1");
      view_check(3, 8'h00, 4'b1000, "post_rst_d3");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
